// File: rtl/fan_eval_scheduler.sv
// fan_eval_scheduler: drives the fan speed controller's reset to force periodic
// re-evaluation, latches the evaluated speed and ramps the fan command toward it
// one step at a time. A watchdog on the evaluation handshake falls back to full
// speed if the controller never answers.
module fan_eval_scheduler #(
  parameter int unsigned PERIOD      = 1000,
  parameter int unsigned PULSE_LEN   = 2,
  parameter int unsigned TIMEOUT     = 8,
  parameter int unsigned RAMP_CYCLES = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       force_eval,
  input  logic       ctrl_speed_set,
  input  logic [1:0] ctrl_fan_speed,
  input  logic [2:0] ctrl_state,
  output logic       eval_pulse,
  output logic [1:0] fan_cmd,
  output logic       cmd_valid,
  output logic       fault,
  output logic [2:0] sched_state
);

  localparam int unsigned PERW = $clog2(PERIOD + 1);
  localparam int unsigned PLSW = $clog2(PULSE_LEN + 1);
  localparam int unsigned TMOW = $clog2(TIMEOUT + 1);
  localparam int unsigned RMPW = $clog2(RAMP_CYCLES + 1);

  // Terminal values: each counter stops at these and is cleared on the state change.
  localparam logic [PERW-1:0] PER_LAST = PERW'(PERIOD - 1);
  localparam logic [PLSW-1:0] PLS_LAST = PLSW'(PULSE_LEN - 1);
  localparam logic [TMOW-1:0] TMO_LAST = TMOW'(TIMEOUT - 1);
  localparam logic [RMPW-1:0] RMP_LAST = RMPW'(RAMP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_PULSE       = 3'd1,
    S_WAIT_SET    = 3'd2,
    S_RAMP        = 3'd3,
    S_WAIT_PERIOD = 3'd4,
    S_FAULT       = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic            eval_pulse_q, eval_pulse_d;
  logic [1:0]      fan_cmd_q, fan_cmd_d;
  logic [1:0]      target_q, target_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic            fault_q, fault_d;
  logic            override_q, override_d;
  logic [PERW-1:0] per_cnt_q, per_cnt_d;
  logic [PLSW-1:0] pls_cnt_q, pls_cnt_d;
  logic [TMOW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [RMPW-1:0] rmp_cnt_q, rmp_cnt_d;

  // Next-state and next-output logic; counters clear whenever their state is left.
  always_comb begin
    state_d     = state_q;
    fan_cmd_d   = fan_cmd_q;
    target_d    = target_q;
    cmd_valid_d = cmd_valid_q;
    fault_d     = fault_q;
    override_d  = override_q;
    per_cnt_d   = '0;
    pls_cnt_d   = '0;
    tmo_cnt_d   = '0;
    rmp_cnt_d   = '0;

    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_PULSE;
        end
        S_PULSE: begin
          if (pls_cnt_q == PLS_LAST) begin
            state_d = S_WAIT_SET;
          end else begin
            pls_cnt_d = pls_cnt_q + PLSW'(1);
          end
        end
        S_WAIT_SET: begin
          // A valid answer wins over a watchdog expiry in the same cycle.
          if (ctrl_speed_set) begin
            target_d    = ctrl_fan_speed;
            override_d  = (ctrl_state == 3'd5) || (ctrl_state == 3'd6);
            fault_d     = 1'b0;
            cmd_valid_d = (ctrl_fan_speed == fan_cmd_q);
            state_d     = S_RAMP;
          end else if (tmo_cnt_q == TMO_LAST) begin
            fault_d     = 1'b1;
            fan_cmd_d   = 2'd3;
            target_d    = 2'd3;
            cmd_valid_d = 1'b1;
            state_d     = S_FAULT;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TMOW'(1);
          end
        end
        S_RAMP: begin
          // Overrides jump straight to the target; normal moves step once per ramp interval.
          if (override_q) begin
            fan_cmd_d = target_q;
          end else if (fan_cmd_q != target_q) begin
            if (rmp_cnt_q == RMP_LAST) begin
              fan_cmd_d = (target_q > fan_cmd_q) ? (fan_cmd_q + 2'd1) : (fan_cmd_q - 2'd1);
            end else begin
              rmp_cnt_d = rmp_cnt_q + RMPW'(1);
            end
          end else begin
            fan_cmd_d = fan_cmd_q;
          end
          // Completion is judged on the value being loaded, so the done flag
          // and the final step appear on the same edge.
          if (fan_cmd_d == target_q) begin
            cmd_valid_d = 1'b1;
            state_d     = S_WAIT_PERIOD;
          end else begin
            cmd_valid_d = 1'b0;
          end
        end
        S_WAIT_PERIOD: begin
          if (force_eval || (per_cnt_q == PER_LAST)) begin
            state_d = S_PULSE;
          end else begin
            per_cnt_d = per_cnt_q + PERW'(1);
          end
        end
        S_FAULT: begin
          fault_d     = 1'b1;
          fan_cmd_d   = 2'd3;
          target_d    = 2'd3;
          cmd_valid_d = 1'b1;
          if (force_eval) begin
            state_d = S_PULSE;
          end else begin
            state_d = S_FAULT;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // The pulse is registered alongside the state so it is high exactly while in PULSE.
    eval_pulse_d = (state_d == S_PULSE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      eval_pulse_q <= 1'b0;
      fan_cmd_q    <= 2'd0;
      target_q     <= 2'd0;
      cmd_valid_q  <= 1'b0;
      fault_q      <= 1'b0;
      override_q   <= 1'b0;
      per_cnt_q    <= '0;
      pls_cnt_q    <= '0;
      tmo_cnt_q    <= '0;
      rmp_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      eval_pulse_q <= eval_pulse_d;
      fan_cmd_q    <= fan_cmd_d;
      target_q     <= target_d;
      cmd_valid_q  <= cmd_valid_d;
      fault_q      <= fault_d;
      override_q   <= override_d;
      per_cnt_q    <= per_cnt_d;
      pls_cnt_q    <= pls_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      rmp_cnt_q    <= rmp_cnt_d;
    end
  end

  assign eval_pulse  = eval_pulse_q;
  assign fan_cmd     = fan_cmd_q;
  assign cmd_valid   = cmd_valid_q;
  assign fault       = fault_q;
  assign sched_state = state_q;

endmodule
